video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16 h front porch; H_SYNC 96 h sync width; H_BP 48 h back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; HS_POL 0 hsync active level; VS_POL 0 vsync active level; CW 12 counter width; GRID_LOG2 5 grid pitch exponent.
REQ-002 clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 en  in  1  pixel-advance enable; when low all state SHALL hold.
REQ-005 mode_i  in  2  pattern select: 0 black, 1 white, 2 colour bars, 3 grid.
REQ-006 counter_x_o / counter_y_o  out  CW  current pixel column / line.
REQ-007 hsync_o, vsync_o, draw_area_o  out  1  syncs (polarity per HS_POL/VS_POL), active-video flag.
REQ-008 frame_start_o, line_start_o  out  1  one-pixel pulses at (0,0) and at x=0.
REQ-009 red_o, green_o, blue_o  out  8 each  pixel colour.
REQ-010 frame_cnt_o  out  16  completed-frame count.

Function
REQ-011 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise; x SHALL count 0..H_TOTAL-1 per en cycle, wrapping to 0 and incrementing y; y SHALL wrap V_TOTAL-1 -> 0.
REQ-012 Order SHALL be active, front porch, sync, back porch; hsync active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; vsync by same rule on y.
REQ-013 draw_area_o SHALL be 1 iff x < H_ACTIVE and y < V_ACTIVE.
REQ-014 All outputs SHALL be registered and mutually aligned: outputs after an en edge describe the pixel just counted (one-cycle latency, no skew between counters, syncs, flags, RGB).
REQ-015 RGB SHALL be 0 whenever draw_area_o is 0.
REQ-016 Colour bars: eight bars of width H_ACTIVE/8 (integer), order white, yellow, cyan, green, magenta, red, blue, black, components 0xFF/0x00; pixels beyond 8*(H_ACTIVE/8) black; generated by a bar-width counter, no divider.
REQ-017 Grid: white where x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0, else black.
REQ-018 mode_i SHALL be sampled only at the last pixel of a frame (x=H_TOTAL-1, y=V_TOTAL-1, en=1); a mid-frame change SHALL take effect at the next frame.
REQ-019 frame_cnt_o SHALL increment at the same wrap event, modulo 2^16.
REQ-020 Parameters whose total exceeds 2^CW SHALL be a elaboration error.

Reset
REQ-021 On rst: counters 0, draw_area_o 0, hsync_o = ~HS_POL, vsync_o = ~VS_POL, pulses 0, RGB 0, frame_cnt_o 0, latched mode 0.
REQ-022 rst SHALL override en; reset mid-frame SHALL restart at (0,0), first en cycle after release giving frame_start_o=1.

Configuration
REQ-023 Macro VIDEO_TIMING_PATTERN_EN: defined -> pattern generator per REQ-016..018; undefined -> mode_i ignored, RGB constant 0 (timing-only build), all timing outputs unchanged.

Verification (H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=VS_POL=0, GRID_LOG2=2)
REQ-024 Free run en=1, 2 frames -> hsync_o low exactly at x=10,11; vsync_o low at y=5; frame period 98 cycles; frame_cnt_o=2.
REQ-025 mode_i=2 -> line 0 RGB per pixel: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; x>=8 -> 0.
REQ-026 mode_i 1->3 switched at (3,2) -> rest of frame white; next frame grid, pixel (4,1) white, (5,1) black.
REQ-027 en toggled 1/0 each cycle -> outputs hold on en=0 cycles; frame period 196 cycles.
REQ-028 rst pulsed at (5,3) -> next cycle outputs reset values; with en=1 next output (0,0), frame_start_o=1, frame_cnt_o=0.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator with registered syncs, flags, counters and optional test patterns.
// Define VIDEO_TIMING_PATTERN_EN to build the pattern generator; otherwise RGB is held at 0.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned CW        = 12,
    parameter int unsigned GRID_LOG2 = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode_i,
    output logic [CW-1:0] counter_x_o,
    output logic [CW-1:0] counter_y_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          draw_area_o,
    output logic          frame_start_o,
    output logic          line_start_o,
    output logic [7:0]    red_o,
    output logic [7:0]    green_o,
    output logic [7:0]    blue_o,
    output logic [15:0]   frame_cnt_o
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    if (64'(H_TOTAL) > (64'd1 << CW) || 64'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_cw
        $error("video_timing_gen: timing totals do not fit in CW bits");
    end
    if (GRID_LOG2 == 0 || GRID_LOG2 > CW) begin : g_bad_grid
        $error("video_timing_gen: GRID_LOG2 out of range");
    end

    // x_q/y_q hold the position of the next pixel to be emitted
    logic [CW-1:0] x_q, y_q, x_d, y_d;
    logic          last_x, last_y, wrap;
    logic          hs_act, vs_act, draw_c;

    always_comb begin
        last_x = (x_q == CW'(H_TOTAL - 1));
        last_y = (y_q == CW'(V_TOTAL - 1));
        wrap   = last_x && last_y;
        x_d    = last_x ? '0 : x_q + CW'(1);
        y_d    = y_q;
        if (last_x) begin
            y_d = last_y ? '0 : y_q + CW'(1);
        end
        hs_act = (x_q >= CW'(HS_START)) && (x_q < CW'(HS_END));
        vs_act = (y_q >= CW'(VS_START)) && (y_q < CW'(VS_END));
        draw_c = (x_q < CW'(H_ACTIVE)) && (y_q < CW'(V_ACTIVE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            counter_x_o   <= '0;
            counter_y_o   <= '0;
            hsync_o       <= ~HS_POL;
            vsync_o       <= ~VS_POL;
            draw_area_o   <= 1'b0;
            frame_start_o <= 1'b0;
            line_start_o  <= 1'b0;
            frame_cnt_o   <= '0;
        end else if (en) begin
            x_q           <= x_d;
            y_q           <= y_d;
            counter_x_o   <= x_q;
            counter_y_o   <= y_q;
            hsync_o       <= hs_act ? HS_POL : ~HS_POL;
            vsync_o       <= vs_act ? VS_POL : ~VS_POL;
            draw_area_o   <= draw_c;
            frame_start_o <= (x_q == '0) && (y_q == '0);
            line_start_o  <= (x_q == '0);
            if (wrap) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end
    end

`ifdef VIDEO_TIMING_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    if (BAR_W == 0) begin : g_bad_bar
        $error("video_timing_gen: H_ACTIVE too small for colour bars");
    end

    logic [1:0]    mode_q;
    logic [CW-1:0] bar_cnt, bar_cnt_d;
    logic [3:0]    bar_idx, bar_idx_d;
    logic [23:0]   rgb_d;

    // Bar tracker follows x_q; index saturates at 8 for the black remainder
    always_comb begin
        bar_cnt_d = bar_cnt + CW'(1);
        bar_idx_d = bar_idx;
        if (last_x) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt == CW'(BAR_W - 1)) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx[3] ? bar_idx : bar_idx + 4'd1;
        end
    end

    // Bar index bits map straight onto the inverted R/G/B enables
    always_comb begin
        rgb_d = '0;
        if (draw_c) begin
            case (mode_q)
                2'd1: rgb_d = '1;
                2'd2: if (!bar_idx[3]) begin
                    rgb_d = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
                end
                2'd3: if (x_q[GRID_LOG2-1:0] == '0 || y_q[GRID_LOG2-1:0] == '0) begin
                    rgb_d = '1;
                end
                default: rgb_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q                  <= '0;
            bar_cnt                 <= '0;
            bar_idx                 <= '0;
            {red_o, green_o, blue_o} <= '0;
        end else if (en) begin
            if (wrap) begin
                mode_q <= mode_i;
            end
            bar_cnt                 <= bar_cnt_d;
            bar_idx                 <= bar_idx_d;
            {red_o, green_o, blue_o} <= rgb_d;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = ^mode_i;
    assign red_o   = '0;
    assign green_o = '0;
    assign blue_o  = '0;
`endif

endmodule
